timer_irq: RTL and testbench

TIMER_IRQ -- requirements
Module: timer_irq

---
 rtl/timer_irq_pkg.sv | 40 ++++
 rtl/timer_irq_if.sv | 32 +++
 rtl/timer_prescaler.sv | 39 +++
 rtl/timer_irq.sv | 145 ++++++++++++++
 tb/tb_timer_irq.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/timer_irq_pkg.sv
// ============================================================================
// Module  : timer_irq_pkg
// Brief   : Shared register map, TCON bit positions and state type for timer_irq.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_irq_pkg;

    localparam logic [31:0] c_OFF_TH   = 32'd0;
    localparam logic [31:0] c_OFF_TL   = 32'd4;
    localparam logic [31:0] c_OFF_TCON = 32'd8;
    localparam logic [31:0] c_OFF_PSC  = 32'd12;

    localparam int c_TCON_RUN  = 0;
    localparam int c_TCON_IEN  = 1;
    localparam int c_TCON_STAT = 2;

    localparam int c_TICK_CNT_RST = 0;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIRED = 2'd2
    } state_e;

    // The timer state is a pure decode of TCON; run=0 dominates a pending status.
    function automatic state_e tcon_state(input logic [2:0] tcon);
        if (!tcon[c_TCON_RUN]) begin
            return ST_STOP;
        end else if (tcon[c_TCON_STAT]) begin
            return ST_FIRED;
        end else begin
            return ST_RUN;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/timer_irq_if.sv
// ============================================================================
// Module  : timer_irq_if
// Brief   : Memory-mapped CPU bus used to access the timer registers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface timer_irq_if;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ReadData;

    modport master (
        output Addr,
        output WriteData,
        output MemRead,
        output MemWrite,
        input  ReadData
    );

    modport slave (
        input  Addr,
        input  WriteData,
        input  MemRead,
        input  MemWrite,
        output ReadData
    );
endinterface

`default_nettype wire

// File: rtl/timer_prescaler.sv
// ============================================================================
// Module  : timer_prescaler
// Brief   : Free-running divider producing one tick every psc+1 enabled cycles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_prescaler
    import timer_irq_pkg::*;
#(
    parameter int PSC_W = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             en,
    input  wire logic [PSC_W-1:0] psc,
    input  wire logic             clr,
    output logic                  tick
);

    localparam logic [PSC_W-1:0] c_CNT_RST = PSC_W'(c_TICK_CNT_RST);

    logic [PSC_W-1:0] r_cnt;

    assign tick = en && (r_cnt == psc);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= c_CNT_RST;
        end else if (clr) begin
            r_cnt <= c_CNT_RST;
        end else if (en) begin
            r_cnt <= tick ? c_CNT_RST : r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/timer_irq.sv
// ============================================================================
// Module  : timer_irq
// Brief   : 32-bit reloading up-counter with prescaler and level interrupt.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_irq
    import timer_irq_pkg::*;
#(
    parameter logic [31:0] BASE  = 32'h4000_0000,
    parameter int          PSC_W = 16
) (
    input  wire logic       clk,
    input  wire logic       reset,
    timer_irq_if.slave      bus,
    output logic            irq
);

    localparam logic [29:0] c_A_TH   = 30'((BASE + c_OFF_TH)   >> 2);
    localparam logic [29:0] c_A_TL   = 30'((BASE + c_OFF_TL)   >> 2);
    localparam logic [29:0] c_A_TCON = 30'((BASE + c_OFF_TCON) >> 2);
    localparam logic [29:0] c_A_PSC  = 30'((BASE + c_OFF_PSC)  >> 2);

    logic [31:0]      r_th;
    logic [31:0]      r_tl;
    logic [2:0]       r_tcon;
    logic [PSC_W-1:0] r_psc;
    logic             r_irq;

    logic [31:0]      w_th_nxt;
    logic [31:0]      w_tl_nxt;
    logic [2:0]       w_tcon_nxt;
    logic [PSC_W-1:0] w_psc_nxt;
    logic             w_irq_nxt;

    logic   w_sel_th, w_sel_tl, w_sel_tcon, w_sel_psc;
    logic   w_wr_th, w_wr_tl, w_wr_tcon, w_wr_psc;
    logic   w_tick;
    logic   w_ovf;
    state_e w_state;
    logic   w_unused_bits;

    assign w_sel_th   = (bus.Addr[31:2] == c_A_TH);
    assign w_sel_tl   = (bus.Addr[31:2] == c_A_TL);
    assign w_sel_tcon = (bus.Addr[31:2] == c_A_TCON);
    assign w_sel_psc  = (bus.Addr[31:2] == c_A_PSC);

    assign w_wr_th   = bus.MemWrite && w_sel_th;
    assign w_wr_tl   = bus.MemWrite && w_sel_tl;
    assign w_wr_tcon = bus.MemWrite && w_sel_tcon;
    assign w_wr_psc  = bus.MemWrite && w_sel_psc;

    assign w_unused_bits = ^{bus.Addr[1:0], bus.WriteData};

    timer_prescaler #(
        .PSC_W (PSC_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (r_tcon[c_TCON_RUN]),
        .psc   (r_psc),
        .clr   (w_wr_psc),
        .tick  (w_tick)
    );

    assign w_ovf = w_tick && (r_tl == 32'hFFFF_FFFF);

    always_comb begin
        w_state    = tcon_state(r_tcon);
        w_th_nxt   = r_th;
        w_tl_nxt   = r_tl;
        w_tcon_nxt = r_tcon;
        w_psc_nxt  = r_psc;
        w_irq_nxt  = r_tcon[c_TCON_STAT] && r_tcon[c_TCON_IEN];

        if (w_wr_th) begin
            w_th_nxt = bus.WriteData;
        end
        if (w_wr_psc) begin
            w_psc_nxt = bus.WriteData[PSC_W-1:0];
        end

        // A bus write to TL beats a same-cycle tick; reload uses the pre-write TH.
        if (w_wr_tl) begin
            w_tl_nxt = bus.WriteData;
        end else if (w_state != ST_STOP && w_tick) begin
            w_tl_nxt = w_ovf ? r_th : r_tl + 32'd1;
        end

        if (w_wr_tcon) begin
            w_tcon_nxt[c_TCON_RUN]  = bus.WriteData[c_TCON_RUN];
            w_tcon_nxt[c_TCON_IEN]  = bus.WriteData[c_TCON_IEN];
            w_tcon_nxt[c_TCON_STAT] = bus.WriteData[c_TCON_STAT]
                                    | (w_ovf & bus.WriteData[c_TCON_IEN]);
        end else begin
            case (w_state)
                ST_RUN: begin
                    if (w_ovf && r_tcon[c_TCON_IEN]) begin
                        w_tcon_nxt[c_TCON_STAT] = 1'b1;
                    end
                end
                ST_FIRED: w_tcon_nxt = r_tcon;
                ST_STOP:  w_tcon_nxt = r_tcon;
                default:  w_tcon_nxt = r_tcon;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_th   <= 32'd0;
            r_tl   <= 32'd0;
            r_tcon <= 3'b000;
            r_psc  <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_th   <= w_th_nxt;
            r_tl   <= w_tl_nxt;
            r_tcon <= w_tcon_nxt;
            r_psc  <= w_psc_nxt;
            r_irq  <= w_irq_nxt;
        end
    end

    always_comb begin
        bus.ReadData = 32'h0;
        if (bus.MemRead) begin
            if (w_sel_th) begin
                bus.ReadData = r_th;
            end else if (w_sel_tl) begin
                bus.ReadData = r_tl;
            end else if (w_sel_tcon) begin
                bus.ReadData = {29'd0, r_tcon};
            end else if (w_sel_psc) begin
                bus.ReadData = 32'(r_psc);
            end
        end
    end

    assign irq = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_timer_irq.sv
// ============================================================================
// Module  : tb_timer_irq
// Brief   : Directed scoreboard bench for timer_irq (reads checked by a monitor).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_irq;

    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [31:0] A_TH   = BASE;
    localparam logic [31:0] A_TL   = BASE + 32'd4;
    localparam logic [31:0] A_TCON = BASE + 32'd8;
    localparam logic [31:0] A_PSC  = BASE + 32'd12;
    localparam logic [31:0] A_BAD  = BASE + 32'd16;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        irq;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic irq;

    int checks = 0;
    int errors = 0;

    exp_t q[$];
    exp_t m_e;

    timer_irq_if bus();

    timer_irq #(
        .BASE  (BASE),
        .PSC_W (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every presented read pops the oldest expectation.
    always @(negedge clk) begin
        if (bus.MemRead === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got %h expected no read", bus.ReadData);
            end else begin
                m_e = q.pop_front();
                chk({m_e.name, "_data"}, bus.ReadData, m_e.data);
                chk({m_e.name, "_irq"}, {31'd0, irq}, {31'd0, m_e.irq});
            end
        end
    end

    task automatic drive(input logic rst_v, input logic rd_v, input logic wr_v,
                         input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        reset         = rst_v;
        bus.MemRead   = rd_v;
        bus.MemWrite  = wr_v;
        bus.Addr      = a;
        bus.WriteData = d;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic eirq,
                      input string name);
        exp_t e;
        e.name = name;
        e.data = exp;
        e.irq  = eirq;
        q.push_back(e);
        drive(1'b0, 1'b1, 1'b0, a, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.Addr      = 32'd0;
        bus.WriteData = 32'd0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

        rd(A_TH,   32'h0, 1'b0, "rst_th");
        rd(A_TL,   32'h0, 1'b0, "rst_tl");
        rd(A_TCON, 32'h0, 1'b0, "rst_tcon");
        rd(A_PSC,  32'h0, 1'b0, "rst_psc");
        wr(A_BAD,  32'h1234_5678);
        rd(A_TH,   32'h0, 1'b0, "bad_wr_ignored");

        // Overflow with reload and interrupt, PSC=0
        wr(A_TH,   32'hFFFF_FFFC);
        wr(A_TL,   32'hFFFF_FFFE);
        wr(A_PSC,  32'h0);
        wr(A_TCON, 32'h3);
        rd(A_TL,   32'hFFFF_FFFE, 1'b0, "ovf_tl0");
        rd(A_TL,   32'hFFFF_FFFF, 1'b0, "ovf_tl1");
        rd(A_TL,   32'hFFFF_FFFC, 1'b0, "ovf_reload");
        rd(A_TCON, 32'h7,         1'b1, "ovf_fired");

        // Clear status while fired; counting keeps going and re-overflows
        wr(A_TCON, 32'h3);
        rd(A_TCON, 32'h3,         1'b1, "clr_tcon");
        rd(A_TCON, 32'h7,         1'b0, "clr_irq_low");
        rd(A_TL,   32'hFFFF_FFFD, 1'b1, "clr_count_on");

        // Stop freezes TL
        wr(A_TCON, 32'h0);
        rd(A_TL,   32'hFFFF_FFFF, 1'b1, "stop_tl0");
        rd(A_TL,   32'hFFFF_FFFF, 1'b0, "stop_tl1");

        // TCON write coinciding with overflow
        wr(A_TCON, 32'h1);
        wr(A_TCON, 32'h3);
        rd(A_TCON, 32'h7,         1'b0, "wr_ovf_stat");
        rd(A_TCON, 32'h7,         1'b1, "wr_ovf_irq");

        // Overflow with irq_en=0: reload only
        wr(A_TCON, 32'h0);
        wr(A_TH,   32'h100);
        wr(A_TCON, 32'h1);
        idle(1);
        rd(A_TL,   32'h100,       1'b0, "noien_reload");
        rd(A_TCON, 32'h1,         1'b0, "noien_stat");

        // Prescaler PSC=3
        wr(A_TCON, 32'h0);
        wr(A_PSC,  32'h3);
        wr(A_TL,   32'h0);
        wr(A_TCON, 32'h1);
        idle(3);
        rd(A_TL,   32'h0,         1'b0, "psc_tl0");
        rd(A_TL,   32'h1,         1'b0, "psc_tl1");
        idle(14);
        rd(A_TL,   32'h4,         1'b0, "psc_tl4");
        rd(A_TL,   32'h5,         1'b0, "psc_tl5");
        rd(A_PSC,  32'h3,         1'b0, "psc_read");

        // TL write on a tick cycle wins
        idle(1);
        wr(A_TL,   32'h50);
        rd(A_TL,   32'h50,        1'b0, "tl_wr_wins");

        // Software-triggered interrupt
        wr(A_TCON, 32'h7);
        rd(A_TCON, 32'h7,         1'b0, "sw_stat");
        rd(A_TCON, 32'h7,         1'b1, "sw_irq");

        // TH write on the overflow cycle: reload uses old TH
        wr(A_PSC,  32'h0);
        wr(A_TL,   32'hFFFF_FFFF);
        wr(A_TH,   32'h200);
        rd(A_TL,   32'h100,       1'b1, "th_old_reload");
        rd(A_TH,   32'h200,       1'b1, "th_new");

        // Reset while fired
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        rd(A_TH,   32'h0, 1'b0, "fired_rst_th");
        rd(A_TL,   32'h0, 1'b0, "fired_rst_tl");
        rd(A_TCON, 32'h0, 1'b0, "fired_rst_tcon");
        rd(A_PSC,  32'h0, 1'b0, "fired_rst_psc");
        rd(A_BAD,  32'h0, 1'b0, "unmapped_read");
        idle(2);
        @(negedge clk);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
